gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
- Iterative greatest-common-divisor engine for two unsigned WIDTH-bit operands, using the subtractive Euclid algorithm.
- Operands arrive packed in one word over a valid/ready input handshake.
- The result is held on out_data with out_valid asserted until the next operand pair is accepted.
- Single clock domain; intended as a small arithmetic accelerator or example datapath.

Parameters:
- WIDTH, 16, operand and result width in bits; in_data is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present on in_data.
- in_data  input  2*WIDTH  operands; A = in_data[2*WIDTH-1:WIDTH], B = in_data[WIDTH-1:0].
- in_ready  output  1  engine can accept an operand pair this cycle.
- out_valid  output  1  out_data holds a completed GCD.
- out_data  output  WIDTH  GCD result.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Reset state: IDLE, in_ready=1, out_valid=0, out_data=0, internal x=y=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=1, out_valid=1.
- Accept: on a rising edge where in_valid && in_ready, load x<=A and y<=B, then enter BUSY.
  - Accepting in DONE clears out_valid on that same edge.
  - in_data is ignored when there is no accept.
- BUSY, per edge:
  - If x==0 or y==0: out_data <= x|y, go to DONE.
  - Else if x>y: x <= x-y.
  - Else: y <= y-x.
- Arithmetic: unsigned, WIDTH bits; subtraction never underflows.
- Zero operands: gcd(a,0)=a, gcd(0,b)=b, gcd(0,0)=0. No hang on zero inputs.
- Latency: out_valid rises N+1 edges after the accept edge, where N is the number of subtraction steps. Example: 48,32 takes 3 steps, so out_valid rises 4 edges after accept.
- DONE is held indefinitely; out_data is stable while out_valid=1.
- in_valid held high in DONE starts a new computation on the next edge, with a new load.
- Reset mid-computation: the next edge returns to IDLE and clears out_valid and out_data. The partial result is discarded.
- Reset has priority over accept on the same edge.
- out_data keeps its last value in IDLE/BUSY, except that reset clears it. Consumers must qualify out_data with out_valid.

Optional Feature:
- Macro GCD_EQ_EXIT_EN.
- Defined: BUSY also terminates when x==y (x≠0), with out_data <= x. This saves one step.
  - Example: 48,32 then gives out_valid 3 edges after accept.
- Undefined: termination only on x==0 or y==0, as specified above.
- Results are identical in both builds; only latency differs.

Test Plan:
- Reset then in_data=32'h0030_0020, in_valid=1 -> out_valid=1 and out_data=16'h0010 within 5 edges after accept (4 without macro, 3 with).
- in_data=32'h0000_0007 -> out_data=7 after 1 BUSY edge; 32'h0000_0000 -> out_data=0, out_valid=1, no hang.
- Coprime 32'h0011_000D (17,13) -> out_data=1; result held stable for 10 cycles while in_valid=0.
- Back-to-back: in_valid held high, 48/32 then 32'h0024_0018 (36,24) -> out_valid drops on the second accept, then out_data=12.
- in_ready=0 throughout BUSY; in_data changes during BUSY do not affect the result 16 for 48/32.
- reset=1 mid-BUSY for one edge -> IDLE, out_valid=0, out_data=0, in_ready=1; a following 48/32 yields 16.

Source files
------------

// File: rtl/gcd_engine.sv
// Subtractive-Euclid GCD engine with a valid/ready operand port and held result.
// Optional macro GCD_EQ_EXIT_EN: also finish when x==y (non-zero), saving one step.
module gcd_engine #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] x, y, x_nx, y_nx, out_data_nx;
  logic             in_ready_nx, out_valid_nx;
  logic             accept_c;

  assign accept_c = in_valid && in_ready;

  // Next-state and next-output logic; every register holds unless changed below.
  always_comb begin
    state_nx     = state;
    x_nx         = x;
    y_nx         = y;
    out_data_nx  = out_data;
    in_ready_nx  = in_ready;
    out_valid_nx = out_valid;
    case (state)
      IDLE, DONE: begin
        if (accept_c) begin
          x_nx         = in_data[2*WIDTH-1:WIDTH];
          y_nx         = in_data[WIDTH-1:0];
          state_nx     = BUSY;
          in_ready_nx  = 1'b0;
          out_valid_nx = 1'b0;
        end
      end
      BUSY: begin
        if ((x == '0) || (y == '0)) begin
          out_data_nx  = x | y;
          state_nx     = DONE;
          in_ready_nx  = 1'b1;
          out_valid_nx = 1'b1;
`ifdef GCD_EQ_EXIT_EN
        end else if (x == y) begin
          out_data_nx  = x;
          state_nx     = DONE;
          in_ready_nx  = 1'b1;
          out_valid_nx = 1'b1;
`endif
        end else if (x > y) begin
          x_nx = x - y;
        end else begin
          y_nx = y - x;
        end
      end
      default: begin
        state_nx     = IDLE;
        in_ready_nx  = 1'b1;
        out_valid_nx = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset wins over any accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      x         <= x_nx;
      y         <= y_nx;
      out_data  <= out_data_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed scenarios plus random pairs vs. a Euclid model.
module tb_gcd_engine;

  localparam int unsigned WIDTH = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [2*WIDTH-1:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;

  int errors = 0;
  int checks = 0;

  gcd_engine #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Reference: modulo Euclid for the value, subtraction count for latency.
  function automatic int unsigned ref_gcd(input int unsigned a_in, input int unsigned b_in);
    int unsigned a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int unsigned ref_latency(input int unsigned a_in, input int unsigned b_in);
    int unsigned a, b, n;
    a = a_in;
    b = b_in;
    n = 0;
    while (a != 0 && b != 0) begin
`ifdef GCD_EQ_EXIT_EN
      if (a == b) break;
`endif
      if (a > b) a = a - b;
      else b = b - a;
      n++;
    end
    return n + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation; returns result, edges-to-valid and whether in_ready ever rose while busy.
  task automatic run_op(input int unsigned a, input int unsigned b,
                        output logic [WIDTH-1:0] res, output int unsigned lat,
                        output bit ready_leak);
    int unsigned budget;
    budget = ref_latency(a, b) + 8;
    ready_leak = 1'b0;
    in_valid = 1'b1;
    in_data  = {WIDTH'(a), WIDTH'(b)};
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < budget) begin
      if (in_ready) ready_leak = 1'b1;
      in_data = 32'($urandom);
      tick();
      lat++;
    end
    res = out_data;
  endtask

  task automatic check_op(input string name, input int unsigned a, input int unsigned b);
    logic [WIDTH-1:0] res;
    int unsigned lat, exp_lat;
    bit leak;
    logic [WIDTH-1:0] exp_res;
    exp_res = WIDTH'(ref_gcd(a, b));
    exp_lat = ref_latency(a, b);
    run_op(a, b, res, lat, leak);
    checks++;
    if (res !== exp_res || !out_valid) begin
      errors++;
      $display("FAIL %s result gcd(%0d,%0d): got %0d valid=%b, expected %0d", name, a, b, res, out_valid, exp_res);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency gcd(%0d,%0d): got %0d edges, expected %0d", name, a, b, lat, exp_lat);
    end
    checks++;
    if (leak) begin
      errors++;
      $display("FAIL %s in_ready while busy: got 1, expected 0", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b, expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset out_data: got %0d, expected 0", out_data); end
  endtask

  task automatic test_basic();
    check_op("basic_48_32", 48, 32);
    check_op("zero_a", 0, 7);
    check_op("zero_b", 7, 0);
    check_op("zero_both", 0, 0);
    check_op("equal", 9, 9);
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] held;
    bit bad;
    check_op("coprime_17_13", 17, 13);
    held = out_data;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'($urandom);
      tick();
      if (!out_valid || out_data !== held || !in_ready) bad = 1'b1;
    end
    checks++;
    if (bad || held !== 16'd1) begin
      errors++;
      $display("FAIL hold: got data=%0d valid=%b, expected 1 held with valid=1", out_data, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n;
    in_valid = 1'b1;
    in_data = 32'h0030_0020;
    tick();
    in_data = 32'h0024_0018;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++;
    if (out_data !== 16'd16 || !out_valid) begin
      errors++;
      $display("FAIL b2b first: got %0d valid=%b, expected 16", out_data, out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b second accept: got valid=%b ready=%b, expected 0 0", out_valid, in_ready);
    end
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++;
    if (out_data !== 16'd12 || !out_valid) begin
      errors++;
      $display("FAIL b2b second: got %0d valid=%b, expected 12", out_data, out_valid);
    end
  endtask

  task automatic test_busy_ignore();
    int unsigned n;
    bit leak;
    in_valid = 1'b1;
    in_data = 32'h0030_0020;
    tick();
    n = 0;
    leak = 1'b0;
    while (!out_valid && n < 20) begin
      if (in_ready) leak = 1'b1;
      in_data = 32'($urandom);
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (out_data !== 16'd16 || !out_valid || leak) begin
      errors++;
      $display("FAIL busy_ignore: got %0d valid=%b leak=%b, expected 16 1 0", out_data, out_valid, leak);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data = 32'h0030_0020;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    in_valid = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b data=%0d ready=%b, expected 0 0 1", out_valid, out_data, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid idle: got valid=%b ready=%b, expected 0 1", out_valid, in_ready);
    end
    check_op("after_reset_48_32", 48, 32);
  endtask

  task automatic test_random();
    int unsigned a, b, k;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(1, 12);
      a = $urandom_range(0, 40) * k;
      b = $urandom_range(0, 40) * k;
      if (i % 9 == 0) b = 0;
      check_op("random", a, b);
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    test_reset();
    test_basic();
    test_hold();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
